qed_dup_queue: RTL and testbench

//  Parametrised successor to the combinational QED transform. Accepts the original

---
 rtl/qed_pkg.sv | 43 ++++
 rtl/qed_sync_fifo.sv | 60 ++++++
 rtl/qed_dup_queue.sv | 158 +++++++++++++++
 tb/tb_qed_dup_queue.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qed_pkg
//  Description : Shared constants, FSM state type and the register/immediate
//                split helpers used to build QED duplicate instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
package qed_pkg;

  // RV32 major opcodes the QED decoder classifies
  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP     = 7'b0110011;
  localparam logic [6:0]  LOAD   = 7'b0000011;
  localparam logic [6:0]  STORE  = 7'b0100011;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // Issue sequencer states
  typedef enum logic [1:0] {
    ORIG  = 2'd0,
    DRAIN = 2'd1,
    DUP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Move a nonzero register index into the duplicate half of the register file:
  // bit 'sb' forced high, bits above it cleared, x0 left alone.
  function automatic logic [4:0] map_reg(input logic [4:0] r, input int sb);
    logic [4:0] low_mask;
    low_mask = (5'b1 << sb) - 5'b1;
    if (r == 5'd0) return 5'd0;
    return (r & low_mask) | (5'b1 << sb);
  endfunction

  // Move a 12-bit memory offset into the duplicate half of the address space:
  // bit 'sb' forced high, bits [11:sb+1] cleared, low bits kept.
  function automatic logic [11:0] split_imm(input logic [11:0] imm, input int sb);
    logic [11:0] low_mask;
    low_mask = (12'b1 << sb) - 12'b1;
    return (imm & low_mask) | (12'b1 << sb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/qed_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : qed_sync_fifo
//  Description : DEPTH x XLEN synchronous first-word-fall-through FIFO holding
//                QED duplicates. Overflow/underflow requests are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module qed_sync_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [XLEN-1:0]                push_data_i,
  input  logic                           pop_i,
  output logic [XLEN-1:0]                head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap naturally on power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/qed_dup_queue.sv
`default_nettype none
// ============================================================================
//  Module      : qed_dup_queue
//  Description : Issues original instructions unchanged while queueing their
//                QED duplicates (register and memory split applied), then
//                replays the queued duplicates on exec_dup.
//  Revision    : 1.0 - initial release
// ============================================================================
module qed_dup_queue
  import qed_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int DEPTH         = 8,
  parameter int REG_SPLIT_BIT = 4,
  parameter int MEM_SPLIT_BIT = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [XLEN-1:0]             in_instruction,
  input  logic                        in_is_i,
  input  logic                        in_is_r,
  input  logic                        in_is_lw,
  input  logic                        in_is_sw,
  input  logic                        exec_dup,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_instruction,
  output logic                        out_is_dup,
  output logic                        dup_done,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        full,
  output logic                        empty
);

  localparam int CW = $clog2(DEPTH+1);

  state_e          state_q;
  logic            out_valid_q;
  logic [XLEN-1:0] out_instr_q;
  logic            out_is_dup_q;

  logic            queueable;
  logic            load_ok;
  logic            accept;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] dup_word;
  logic [XLEN-1:0] fifo_head;
  logic [11:0]     s_imm;

  // Build the duplicate word; decoder flags resolved with priority I > LW > R > SW
  always_comb begin
    queueable = in_is_i || in_is_lw || in_is_r || in_is_sw;
    dup_word  = in_instruction;
    s_imm     = split_imm({in_instruction[31:25], in_instruction[11:7]}, MEM_SPLIT_BIT);
    if (in_is_i) begin
      dup_word[11:7]  = map_reg(in_instruction[11:7],  REG_SPLIT_BIT);
      dup_word[19:15] = map_reg(in_instruction[19:15], REG_SPLIT_BIT);
    end else if (in_is_lw) begin
      dup_word[11:7]  = map_reg(in_instruction[11:7],  REG_SPLIT_BIT);
      dup_word[19:15] = map_reg(in_instruction[19:15], REG_SPLIT_BIT);
      dup_word[31:20] = split_imm(in_instruction[31:20], MEM_SPLIT_BIT);
    end else if (in_is_r) begin
      dup_word[11:7]  = map_reg(in_instruction[11:7],  REG_SPLIT_BIT);
      dup_word[19:15] = map_reg(in_instruction[19:15], REG_SPLIT_BIT);
      dup_word[24:20] = map_reg(in_instruction[24:20], REG_SPLIT_BIT);
    end else if (in_is_sw) begin
      // Only imm[11:5] carries split bits; imm[4:0] in rd field stays as is
      dup_word[19:15] = map_reg(in_instruction[19:15], REG_SPLIT_BIT);
      dup_word[24:20] = map_reg(in_instruction[24:20], REG_SPLIT_BIT);
      dup_word[31:25] = s_imm[11:5];
    end
  end

  // The output register may take a new word when empty or being consumed.
  // Requesting replay blocks new originals in the same cycle so nothing
  // slips in behind the duplicates.
  assign load_ok  = !out_valid_q || out_ready;
  assign in_ready = (state_q == ORIG) && load_ok
                    && !(ena && queueable && full)
                    && !(ena && exec_dup);
  assign accept   = in_valid && in_ready;
  assign push     = accept && ena && queueable;
  assign pop      = (state_q == DUP) && load_ok && !empty;

  qed_sync_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (dup_word),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Sequencer and output register: originals in ORIG, FIFO replay in DUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ORIG;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_is_dup_q <= 1'b0;
    end else begin
      case (state_q)
        ORIG: begin
          if (accept) begin
            out_valid_q  <= 1'b1;
            out_instr_q  <= in_instruction;
            out_is_dup_q <= 1'b0;
          end else if (load_ok) begin
            out_valid_q <= 1'b0;
          end
          if (ena && exec_dup) state_q <= DRAIN;
        end
        DRAIN: begin
          // Let the last original leave before duplicates take the register
          if (load_ok) begin
            out_valid_q <= 1'b0;
            state_q     <= empty ? DONE : DUP;
          end
        end
        DUP: begin
          if (load_ok) begin
            if (!empty) begin
              out_valid_q  <= 1'b1;
              out_instr_q  <= fifo_head;
              out_is_dup_q <= 1'b1;
              if (count == CW'(1)) state_q <= DONE;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (load_ok) out_valid_q <= 1'b0;
          if (!exec_dup) state_q <= ORIG;
        end
        default: state_q <= ORIG;
      endcase
    end
  end

  assign out_valid       = out_valid_q;
  assign out_instruction = out_instr_q;
  assign out_is_dup      = out_is_dup_q;
  assign dup_done        = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_qed_dup_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qed_dup_queue
//  Description : Self-checking bench for qed_dup_queue with a queue-based
//                reference model of the original and duplicate streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qed_dup_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int RSB   = 4;
  localparam int MSB   = 10;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_instruction = '0;
  logic            in_is_i = 1'b0, in_is_r = 1'b0, in_is_lw = 1'b0, in_is_sw = 1'b0;
  logic            exec_dup = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_instruction;
  logic            out_is_dup;
  logic            dup_done;
  logic [CW-1:0]   count;
  logic            full, empty;

  qed_dup_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_SPLIT_BIT(RSB), .MEM_SPLIT_BIT(MSB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_is_i(in_is_i), .in_is_r(in_is_r),
    .in_is_lw(in_is_lw), .in_is_sw(in_is_sw), .exec_dup(exec_dup),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_is_dup(out_is_dup), .dup_done(dup_done), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];      // {is_dup, word} expected on the output, in order
  logic [31:0] fifo_m[$];     // duplicates queued but not yet replayed
  logic cnt_check_en = 1'b0;
  logic rand_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference transform written arithmetically from the split rules
  function automatic logic [4:0] mreg(input logic [4:0] r);
    if (r == 5'd0) return 5'd0;
    return 5'((int'(r) % (1 << RSB)) + (1 << RSB));
  endfunction

  function automatic logic [11:0] mimm(input logic [11:0] v);
    return 12'((int'(v) % (1 << MSB)) + (1 << MSB));
  endfunction

  function automatic logic [31:0] ref_dup(input logic [31:0] w, input logic fi, input logic fl,
                                          input logic fr, input logic fs);
    logic [31:0] d;
    logic [11:0] s;
    d = w;
    s = mimm({w[31:25], w[11:7]});
    if (fi) begin
      d[11:7] = mreg(w[11:7]); d[19:15] = mreg(w[19:15]);
    end else if (fl) begin
      d[11:7] = mreg(w[11:7]); d[19:15] = mreg(w[19:15]); d[31:20] = mimm(w[31:20]);
    end else if (fr) begin
      d[11:7] = mreg(w[11:7]); d[19:15] = mreg(w[19:15]); d[24:20] = mreg(w[24:20]);
    end else if (fs) begin
      d[19:15] = mreg(w[19:15]); d[24:20] = mreg(w[24:20]); d[31:25] = s[11:5];
    end
    return d;
  endfunction

  // Random ready pattern when enabled
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: records accepted originals/duplicates and checks every issued word
  logic        stall_prev = 1'b0;
  logic [31:0] held = '0;
  always @(negedge clk) begin
    logic [32:0] e;
    logic        q;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      q = in_is_i | in_is_lw | in_is_r | in_is_sw;
      if (stall_prev) begin
        check_eq("hold_word", out_instruction, held);
        check_eq("hold_valid", out_valid, 1);
      end
      if (cnt_check_en) begin
        check_eq("count", count, fifo_m.size());
        check_eq("full", full, fifo_m.size() == DEPTH);
        check_eq("empty", empty, fifo_m.size() == 0);
        if (in_valid && ena && q && fifo_m.size() == DEPTH)
          check_eq("bp_in_ready", in_ready, 0);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_instruction});
        if (ena && q) fifo_m.push_back(ref_dup(in_instruction, in_is_i, in_is_lw, in_is_r, in_is_sw));
      end
      if (out_valid && out_ready) begin
        check_eq("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("out_word", out_instruction, e[31:0]);
          check_eq("out_is_dup", out_is_dup, e[32]);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = out_instruction;
    end
  end

  // Present one original until accepted, then idle the input
  task automatic send(input logic [31:0] w, input logic [3:0] fl, input logic en);
    logic ok;
    in_instruction = w;
    {in_is_i, in_is_lw, in_is_r, in_is_sw} = fl;
    ena = en;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check_eq("send_accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    {in_is_i, in_is_lw, in_is_r, in_is_sw} = 4'b0;
  endtask

  task automatic exec_start();
    cnt_check_en = 1'b0;
    in_valid = 1'b0;
    ena = 1'b1;
    while (fifo_m.size() > 0) exp_q.push_back({1'b1, fifo_m.pop_front()});
    exec_dup = 1'b1;
  endtask

  task automatic wait_dup();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid && out_is_dup) begin ok = 1'b1; break; end
    end
    check_eq("dup_seen", ok, 1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("drain", ok, 1);
  endtask

  task automatic exec_finish();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dup_done) begin ok = 1'b1; break; end
    end
    check_eq("dup_done_wait", ok, 1);
    drain();
    @(negedge clk);
    check_eq("post_count", count, 0);
    check_eq("post_empty", empty, 1);
    check_eq("post_dup_done", dup_done, 1);
    @(posedge clk); #1;
    exec_dup = 1'b0;
    @(posedge clk); #1;
    check_eq("dup_done_clear", dup_done, 0);
    cnt_check_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [3:0]  fl;
    logic        en_r;
    logic [CW-1:0] cnt_hold;
    logic        ok;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_instr", out_instruction, 0);
    check_eq("rst_out_is_dup", out_is_dup, 0);
    check_eq("rst_dup_done", dup_done, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt_check_en = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // ---- addi x1,x1,5 and sw x2,0x7E4(x3)
    send(32'h0050_8093, 4'b1000, 1'b1);
    check_eq("addi_out", out_instruction, 32'h0050_8093);
    check_eq("addi_out_valid", out_valid, 1);
    check_eq("addi_count", count, 1);
    w = {7'b0111111, 5'd2, 5'd3, 3'b010, 5'b00100, 7'b0100011};
    send(w, 4'b0001, 1'b1);
    exec_start();
    wait_dup();
    check_eq("addi_dup", out_instruction, 32'h0058_8893);
    @(negedge clk);
    check_eq("sw_dup_flag", out_is_dup, 1);
    check_eq("sw_dup_imm_hi", out_instruction[31:30], 2'b01);
    check_eq("sw_dup_rs1", out_instruction[19:15], 5'd19);
    check_eq("sw_dup_rs2", out_instruction[24:20], 5'd18);
    check_eq("sw_dup_imm_lo", out_instruction[11:7], 5'b00100);
    exec_finish();

    // ---- fill to DEPTH, backpressure, replay with a 3-cycle stall
    for (int k = 0; k < DEPTH; k++) begin
      fl = 4'($urandom_range(1, 15));
      send($urandom, fl, 1'b1);
    end
    @(negedge clk);
    check_eq("fill_full", full, 1);
    check_eq("fill_count", count, DEPTH);
    @(posedge clk); #1;
    in_instruction = $urandom; in_is_r = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("ninth_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_r = 1'b0;
    exec_start();
    wait_dup();
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    cnt_hold = count;
    repeat (3) begin
      @(negedge clk);
      check_eq("stall_count", count, cnt_hold);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    exec_finish();

    // ---- ena low: exec_dup ignored, pure pass-through
    exec_dup = 1'b1;
    for (int k = 0; k < 4; k++) send($urandom, 4'b0010, 1'b0);
    drain();
    @(negedge clk);
    check_eq("noena_count", count, 0);
    check_eq("noena_dup_done", dup_done, 0);
    check_eq("noena_in_ready", in_ready, 1);
    @(posedge clk); #1;
    exec_dup = 1'b0;

    // ---- randomized rounds
    rand_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      en_r = (r % 3) != 2;
      for (int k = 0; k < int'($urandom_range(3, 12)); k++) begin
        w  = $urandom;
        fl = 4'($urandom_range(0, 15));
        ok = en_r && ($urandom_range(0, 4) != 0);
        if (ok && fl != 4'b0 && fifo_m.size() == DEPTH) fl = 4'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(w, fl, ok);
      end
      if (en_r) begin
        exec_start();
        exec_finish();
      end else begin
        exec_dup = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rnd_noena_dup_done", dup_done, 0);
        @(posedge clk); #1;
        exec_dup = 1'b0;
        drain();
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // ---- asynchronous reset in the middle of replay
    for (int k = 0; k < 4; k++) send($urandom, 4'b0100, 1'b1);
    exec_start();
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_is_dup && count == CW'(3)) begin ok = 1'b1; break; end
    end
    check_eq("mid_dup_count3", ok, 1);
    #2;
    rst_n = 1'b0;
    exec_dup = 1'b0;
    exp_q.delete();
    fifo_m.delete();
    #1;
    check_eq("arst_count", count, 0);
    check_eq("arst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_in_ready", in_ready, 1);
    check_eq("arst_dup_done", dup_done, 0);
    check_eq("arst_empty", empty, 1);
    cnt_check_en = 1'b1;
    send(32'h0050_8093, 4'b1000, 1'b1);
    check_eq("arst_resume_out", out_instruction, 32'h0050_8093);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
